// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: handshaked inter-stage pipeline register carrying an
// opaque payload plus a control bundle. An optional second (skid) entry lets
// IN_READY come straight from a register, so OUT_READY never reaches
// upstream combinationally. FLUSH kills everything held; STALL_CNT counts
// back-pressure cycles and saturates.
module elastic_pipe_reg #(
  parameter int unsigned       DATA_W   = 128,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter bit                SKID     = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY,
  output logic [15:0]       STALL_CNT
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   m_data, s_data;
  logic [CTRL_W-1:0]   m_ctrl, s_ctrl;
  logic                m_valid, s_valid;
  logic                in_fire, out_fire;
  logic                m_load_in, m_load_s, s_load;
  logic [15:0]         stall_q;

  // Entry valid bits are encoded in the state register rather than kept as
  // separate flops, so they can never disagree with the FSM.
  assign m_valid  = (state_q != EMPTY);
  assign s_valid  = (state_q == FULL);
  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = m_valid & OUT_READY;

  // Upstream ready: registered skid flag (masked during reset) or classic pass-through.
  always_comb begin
    if (SKID) IN_READY = ~s_valid & ~RESET;
    else      IN_READY = ~m_valid | OUT_READY;
  end

  // Next-state and load-select decode; flush overrides any movement.
  always_comb begin
    state_d   = state_q;
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    s_load    = 1'b0;
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            m_load_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_load_in = 1'b1;
          end else if (in_fire) begin
            if (SKID) begin
              state_d = FULL;
              s_load  = 1'b1;
            end
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d  = ONE;
            m_load_s = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry storage; data is left untouched on flush so OUT_DATA holds.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      m_data  <= '0;
      m_ctrl  <= CTRL_NOP;
      s_data  <= '0;
      s_ctrl  <= CTRL_NOP;
    end else begin
      state_q <= state_d;
      if (m_load_in) begin
        m_data <= IN_DATA;
        m_ctrl <= IN_CTRL;
      end else if (m_load_s) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end
      if (s_load) begin
        s_data <= IN_DATA;
        s_ctrl <= IN_CTRL;
      end
    end
  end

  // Saturating back-pressure counter, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (m_valid && !OUT_READY && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign OUT_VALID = m_valid;
  assign OUT_DATA  = m_data;
  assign OUT_CTRL  = m_valid ? m_ctrl : CTRL_NOP;
  assign OCCUPANCY = {s_valid, m_valid & ~s_valid};
  assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: a vector table exercises the skid
// instance (stream, back-pressure, flush, mid-stream reset), then hand
// sequences cover the pass-through instance and counter saturation.
module tb_elastic_pipe_reg;

  localparam logic [3:0] NOP = 4'hF;

  logic        CLK;
  logic        RESET;

  logic        iv, ir, fl, ov, ordy;
  logic [15:0] id, od, st;
  logic [3:0]  ic, oc;
  logic [1:0]  occ;

  logic        iv0, ir0, fl0, ov0, ordy0;
  logic [15:0] id0, od0, st0;
  logic [3:0]  ic0, oc0;
  logic [1:0]  occ0;

  int tests = 0;
  int fails = 0;

  elastic_pipe_reg #(.DATA_W(16), .CTRL_W(4), .CTRL_NOP(NOP), .SKID(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(iv), .IN_READY(ir), .IN_DATA(id), .IN_CTRL(ic),
    .FLUSH(fl), .OUT_VALID(ov), .OUT_READY(ordy), .OUT_DATA(od), .OUT_CTRL(oc),
    .OCCUPANCY(occ), .STALL_CNT(st)
  );

  elastic_pipe_reg #(.DATA_W(16), .CTRL_W(4), .CTRL_NOP(NOP), .SKID(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(iv0), .IN_READY(ir0), .IN_DATA(id0), .IN_CTRL(ic0),
    .FLUSH(fl0), .OUT_VALID(ov0), .OUT_READY(ordy0), .OUT_DATA(od0), .OUT_CTRL(oc0),
    .OCCUPANCY(occ0), .STALL_CNT(st0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, iv;
    logic [15:0] d;
    logic [3:0]  c;
    logic        fl, ordy;
    logic        e_ir, e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_oc;
    logic [1:0]  e_occ;
    logic [15:0] e_st;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic rst, logic v, logic [15:0] d, logic [3:0] c, logic f,
                              logic r, logic e_ir, logic e_ov, logic [15:0] e_od,
                              logic [3:0] e_oc, logic [1:0] e_occ, logic [15:0] e_st);
    vec_t t;
    t.rst = rst; t.iv = v; t.d = d; t.c = c; t.fl = f; t.ordy = r;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_oc = e_oc; t.e_occ = e_occ; t.e_st = e_st;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            rst iv d      c     fl ordy | ir ov od     oc    occ st
    tbl[0]  = mk(1, 0, 16'd0,  4'd0, 0, 1,    0, 0, 16'd0,  NOP,  0, 16'd0);
    tbl[1]  = mk(0, 1, 16'd0,  4'd1, 0, 1,    1, 0, 16'd0,  NOP,  0, 16'd0);
    tbl[2]  = mk(0, 1, 16'd1,  4'd2, 0, 1,    1, 1, 16'd0,  4'd1, 1, 16'd0);
    tbl[3]  = mk(0, 1, 16'd2,  4'd3, 0, 1,    1, 1, 16'd1,  4'd2, 1, 16'd0);
    tbl[4]  = mk(0, 1, 16'd3,  4'd4, 0, 1,    1, 1, 16'd2,  4'd3, 1, 16'd0);
    tbl[5]  = mk(0, 1, 16'd10, 4'd5, 0, 1,    1, 1, 16'd3,  4'd4, 1, 16'd0);
    tbl[6]  = mk(0, 1, 16'd11, 4'd6, 0, 1,    1, 1, 16'd10, 4'd5, 1, 16'd0);
    tbl[7]  = mk(0, 1, 16'd12, 4'd7, 0, 0,    1, 1, 16'd11, 4'd6, 1, 16'd0);
    tbl[8]  = mk(0, 0, 16'd0,  4'd0, 0, 0,    0, 1, 16'd11, 4'd6, 2, 16'd1);
    tbl[9]  = mk(0, 0, 16'd0,  4'd0, 0, 0,    0, 1, 16'd11, 4'd6, 2, 16'd2);
    tbl[10] = mk(0, 0, 16'd0,  4'd0, 0, 1,    0, 1, 16'd11, 4'd6, 2, 16'd3);
    tbl[11] = mk(0, 0, 16'd0,  4'd0, 0, 1,    1, 1, 16'd12, 4'd7, 1, 16'd3);
    tbl[12] = mk(0, 0, 16'd0,  4'd0, 0, 1,    1, 0, 16'd12, NOP,  0, 16'd3);
    tbl[13] = mk(0, 1, 16'd20, 4'd1, 0, 0,    1, 0, 16'd12, NOP,  0, 16'd3);
    tbl[14] = mk(0, 1, 16'd21, 4'd2, 0, 0,    1, 1, 16'd20, 4'd1, 1, 16'd3);
    tbl[15] = mk(0, 1, 16'd22, 4'd3, 1, 0,    0, 1, 16'd20, 4'd1, 2, 16'd4);
    tbl[16] = mk(0, 0, 16'd0,  4'd0, 0, 0,    1, 0, 16'd20, NOP,  0, 16'd5);
    tbl[17] = mk(0, 1, 16'd30, 4'd4, 0, 1,    1, 0, 16'd20, NOP,  0, 16'd5);
    tbl[18] = mk(0, 1, 16'd31, 4'd5, 1, 1,    1, 1, 16'd30, 4'd4, 1, 16'd5);
    tbl[19] = mk(0, 0, 16'd0,  4'd0, 0, 1,    1, 0, 16'd30, NOP,  0, 16'd5);
    tbl[20] = mk(0, 1, 16'd40, 4'd6, 0, 0,    1, 0, 16'd30, NOP,  0, 16'd5);
    tbl[21] = mk(0, 1, 16'd41, 4'd7, 0, 0,    1, 1, 16'd40, 4'd6, 1, 16'd5);
    tbl[22] = mk(1, 0, 16'd0,  4'd0, 0, 0,    0, 1, 16'd40, 4'd6, 2, 16'd6);
    tbl[23] = mk(0, 1, 16'd50, 4'd8, 0, 1,    1, 0, 16'd0,  NOP,  0, 16'd0);
    tbl[24] = mk(0, 0, 16'd0,  4'd0, 0, 1,    1, 1, 16'd50, 4'd8, 1, 16'd0);
    tbl[25] = mk(0, 0, 16'd0,  4'd0, 0, 1,    1, 0, 16'd50, NOP,  0, 16'd0);

    RESET = 1'b1;
    iv = 0; id = '0; ic = '0; fl = 0; ordy = 1;
    iv0 = 0; id0 = '0; ic0 = '0; fl0 = 0; ordy0 = 0;
    repeat (2) tick();

    for (int i = 0; i < 26; i++) begin
      RESET = tbl[i].rst; iv = tbl[i].iv; id = tbl[i].d; ic = tbl[i].c;
      fl = tbl[i].fl; ordy = tbl[i].ordy;
      #1;
      chk("in_ready",  i, 32'(ir),  32'(tbl[i].e_ir));
      chk("out_valid", i, 32'(ov),  32'(tbl[i].e_ov));
      chk("out_data",  i, 32'(od),  32'(tbl[i].e_od));
      chk("out_ctrl",  i, 32'(oc),  32'(tbl[i].e_oc));
      chk("occupancy", i, 32'(occ), 32'(tbl[i].e_occ));
      chk("stall_cnt", i, 32'(st),  32'(tbl[i].e_st));
      tick();
    end

    // Pass-through instance: ready follows downstream combinationally.
    RESET = 0; iv = 0; fl = 0; ordy = 1;
    iv0 = 1; id0 = 16'd100; ic0 = 4'd1; ordy0 = 0;
    #1;
    chk("s0_ready_empty", 0, 32'(ir0), 32'd1);
    chk("s0_valid_empty", 0, 32'(ov0), 32'd0);
    chk("s0_occ_empty",   0, 32'(occ0), 32'd0);
    tick();
    id0 = 16'd101; ic0 = 4'd2;
    #1;
    chk("s0_ready_blocked", 1, 32'(ir0), 32'd0);
    chk("s0_data_held",     1, 32'(od0), 32'd100);
    chk("s0_ctrl_held",     1, 32'(oc0), 32'd1);
    chk("s0_occ_held",      1, 32'(occ0), 32'd1);
    tick();
    ordy0 = 1;
    #1;
    chk("s0_ready_same_cycle", 2, 32'(ir0), 32'd1);
    chk("s0_occ_max1",         2, 32'(occ0), 32'd1);
    chk("s0_data_hold2",       2, 32'(od0), 32'd100);
    tick();
    iv0 = 0;
    #1;
    chk("s0_data_next", 3, 32'(od0), 32'd101);
    chk("s0_ctrl_next", 3, 32'(oc0), 32'd2);
    chk("s0_occ_next",  3, 32'(occ0), 32'd1);
    chk("s0_stall",     3, 32'(st0), 32'd1);
    tick();
    #1;
    chk("s0_valid_drain", 4, 32'(ov0), 32'd0);
    chk("s0_ctrl_drain",  4, 32'(oc0), 32'(NOP));
    chk("s0_occ_drain",   4, 32'(occ0), 32'd0);

    // Saturation: one entry held against a stalled consumer.
    iv = 1; id = 16'd60; ic = 4'd9; ordy = 0;
    #1;
    chk("sat_ready", 0, 32'(ir), 32'd1);
    tick();
    iv = 0;
    #1;
    chk("sat_valid", 1, 32'(ov), 32'd1);
    chk("sat_start", 1, 32'(st), 32'd0);
    repeat (65534) tick();
    chk("sat_fffe", 2, 32'(st), 32'h0000_FFFE);
    repeat (4466) tick();
    chk("sat_ffff", 3, 32'(st), 32'h0000_FFFF);
    chk("sat_data", 3, 32'(od), 32'd60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, handshaked inter-stage pipeline register for the RV32IM pipeline. It replaces fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries an opaque datapath payload and a control bundle. Stage-to-stage flow uses a valid/ready handshake with an optional two-entry skid buffer, so stalls no longer need a global enable. Flush kills all in-flight entries, and a saturating counter reports back-pressure cycles.

## Interface
- DATA_W, 128, datapath payload width (PC+4, operands, immediate, destination register, ...)
- CTRL_W, 16, control bundle width (ALU op, mem read/write, reg write enable, ...)
- CTRL_NOP, {CTRL_W{1'b0}}, control value presented whenever no valid entry is output
- SKID, 1, 1 = two-entry skid buffer with registered IN_READY; 0 = single entry with combinational IN_READY
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- IN_VALID  input  1  upstream stage holds a valid entry
- IN_READY  output  1  block accepts an entry this cycle
- IN_DATA  input  DATA_W  upstream payload
- IN_CTRL  input  CTRL_W  upstream control bundle
- FLUSH  input  1  control-hazard kill of all held entries and of this cycle's input
- OUT_VALID  output  1  downstream entry valid
- OUT_READY  input  1  downstream accepts the entry
- OUT_DATA  output  DATA_W  payload of the head entry
- OUT_CTRL  output  CTRL_W  control of the head entry; CTRL_NOP when OUT_VALID=0
- OCCUPANCY  output  2  number of held entries (0..2)
- STALL_CNT  output  16  saturating count of cycles with OUT_VALID=1 and OUT_READY=0

## Operation
- Storage: main entry M (valid, data, ctrl) drives the outputs. Skid entry S exists only when SKID=1.
- Handshake: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY. Neither side may make valid depend on ready.
- SKID=1: IN_READY = !S.valid, taken directly from a register. States are EMPTY (M, S invalid), ONE (M valid), and FULL (M, S valid).
  - EMPTY: in_fire goes to ONE, with M <= input.
  - ONE: in_fire & out_fire stays ONE, with M <= input. in_fire only goes to FULL, with S <= input. out_fire only goes to EMPTY.
  - FULL: IN_READY=0. out_fire goes to ONE, with M <= S and S invalidated.
- SKID=0: IN_READY = !M.valid | OUT_READY. FULL is unreachable, and OCCUPANCY never exceeds 1.
- FLUSH (priority over all except RESET):
  - Next edge: M.valid = S.valid = 0, state becomes EMPTY.
  - Any in_fire in the flush cycle still completes on the upstream side, but its data is discarded.
  - OUT_DATA keeps its last value; OUT_CTRL shows CTRL_NOP.
- OUT_CTRL = M.valid ? M.ctrl : CTRL_NOP. This gating is combinational, so a bubble can never assert write enables.
- OUT_DATA = M.data regardless of valid.
- STALL_CNT increments by 1 every cycle OUT_VALID & !OUT_READY, saturates at 16'hFFFF, and is cleared only by RESET. FLUSH does not clear it.
- RESET values: M/S valid 0, data 0, ctrl CTRL_NOP, OUT_VALID 0, OUT_DATA 0, OUT_CTRL CTRL_NOP, OCCUPANCY 0, STALL_CNT 0.
- IN_READY in reset:
  - SKID=1: 1 on the first cycle after RESET deasserts, held low while RESET is high.
  - SKID=0: follows its equation.
- RESET in mid-stream drops all entries with no partial transfer.

## Timing
- Latency: entry accepted at edge N is visible on OUT_* after edge N (OUT_VALID=1 in cycle N+1).
- Throughput: 1 entry/cycle sustained when OUT_READY=1.
- SKID=1: OUT_READY may drop with no upstream combinational path. Up to 1 extra entry is absorbed, and IN_READY falls one cycle later. No entry is lost or duplicated.
- FLUSH takes effect at the edge where it is sampled. OUT_VALID=0 in the following cycle.
- Simultaneous FLUSH & RESET: RESET wins. Simultaneous FLUSH & out_fire: the downstream transfer completes that cycle; the flush applies to the state afterwards.
- OCCUPANCY and STALL_CNT are registered, updated at the same edge as the state.

## Test plan
- Streaming:
  - Stimulus: SKID=1, OUT_READY=1, IN_VALID=1, IN_DATA=0,1,2,...
  - Required: OUT_DATA=0,1,2,... one cycle later, OCCUPANCY=1 throughout, STALL_CNT=0.
- Back-pressure:
  - Stimulus: stream 10,11,12, drop OUT_READY for 3 cycles, then raise it.
  - Required: FULL holds 11 (M) and 12 (S); IN_READY=0 while FULL; output order 10,11,12 with none lost; STALL_CNT=3.
- Flush:
  - Stimulus: FULL state with IN_VALID=1 and FLUSH=1 for one cycle.
  - Required: next cycle OUT_VALID=0, OUT_CTRL=CTRL_NOP, OCCUPANCY=0, OUT_DATA unchanged; the flush-cycle input never appears at the output.
- Reset mid-stream:
  - Stimulus: RESET=1 for one cycle during back-pressure.
  - Required: all outputs return to the reset values above, STALL_CNT=0, and the next accepted entry appears normally.
- SKID=0 instance:
  - Stimulus: OUT_READY=0 with IN_VALID=1, then OUT_READY=1.
  - Required: IN_READY=0 while M is valid and OUT_READY=0; IN_READY=1 in the same cycle OUT_READY rises; OCCUPANCY never reaches 2.
- Saturation:
  - Stimulus: hold OUT_VALID=1 with OUT_READY=0 for 70000 cycles.
  - Required: STALL_CNT=16'hFFFF with no wrap.
